// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: grant FSM encoding,
// requester IDs and the streak counter width helper.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_BUSY_IF = 2'd1,
      ARB_BUSY_DM = 2'd2
   } arbState_t;

   localparam logic ARB_ID_IF = 1'b0;
   localparam logic ARB_ID_DM = 1'b1;

   // Bits needed to hold 0..maxStreak inclusive.
   function automatic int streakWidth(input int maxStreak);
      return (maxStreak < 1) ? 1 : $clog2(maxStreak + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// slave = the arbiter itself, master = requesters plus memory model.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Handshake: x_req is a level held until the matching x_done pulse; mem_req is
   // held with stable mem_* until mem_ready is sampled high while the arbiter is busy.
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_done;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_done, if_rdata, dm_done, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_done, if_rdata, dm_done, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_port_arbiter_dm_streak_counter.sv
// Saturating count of consecutive DM grants taken while fetch was waiting.
// at_limit tells the arbiter to hand the next grant to fetch.
module mem_port_arbiter_dm_streak_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_DM_STREAK = 4,
   localparam int STREAK_W = streakWidth(MAX_DM_STREAK)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inc,
   input  logic                clr,
   output logic [STREAK_W-1:0] count,
   output logic                at_limit
);

   localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(MAX_DM_STREAK);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc && !at_limit) begin
         count <= count + STREAK_W'(1);
      end
   end

   assign at_limit = (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, data first,
// with a streak limit so fetch cannot starve. Optional perf counters: ARB_PERF_CNT_EN.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int MAX_DM_STREAK = 4,
   localparam int STREAK_W = streakWidth(MAX_DM_STREAK)
) (
   input  logic                clk,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus,
`ifdef ARB_PERF_CNT_EN
   output logic [31:0]         perf_conflict_cnt,
   output logic [31:0]         perf_if_stall_cnt,
`endif
   output arbState_t           dbgState,
   output logic [STREAK_W-1:0] dbgStreak,
   output logic                dbgLastId
);

   arbState_t         state, stateNext;
   logic              memReq, memReqNext;
   logic              memWe, memWeNext;
   logic [ADDR_W-1:0] memAddr, memAddrNext;
   logic [DATA_W-1:0] memWdata, memWdataNext;
   logic              ifDone, ifDoneNext;
   logic              dmDone, dmDoneNext;
   logic [DATA_W-1:0] ifRdata, ifRdataNext;
   logic [DATA_W-1:0] dmRdata, dmRdataNext;
   logic              lastId, lastIdNext;

   logic ifElig, dmElig;
   logic grantIf, grantDm;
   logic streakInc, streakClr, streakAtLimit;

   // A requester still holding req on its own done cycle is not asking again.
   assign ifElig = bus.if_req && !ifDone;
   assign dmElig = bus.dm_req && !dmDone;

   always_comb begin
      stateNext    = state;
      memReqNext   = memReq;
      memWeNext    = memWe;
      memAddrNext  = memAddr;
      memWdataNext = memWdata;
      ifDoneNext   = 1'b0;
      dmDoneNext   = 1'b0;
      ifRdataNext  = ifRdata;
      dmRdataNext  = dmRdata;
      lastIdNext   = lastId;
      grantIf      = 1'b0;
      grantDm      = 1'b0;

      case (state)
         ARB_IDLE: begin
            if (dmElig && (!ifElig || !streakAtLimit)) begin
               grantDm      = 1'b1;
               stateNext    = ARB_BUSY_DM;
               memReqNext   = 1'b1;
               memWeNext    = bus.dm_we;
               memAddrNext  = bus.dm_addr;
               memWdataNext = bus.dm_wdata;
               lastIdNext   = ARB_ID_DM;
            end else if (ifElig) begin
               grantIf      = 1'b1;
               stateNext    = ARB_BUSY_IF;
               memReqNext   = 1'b1;
               memWeNext    = 1'b0;
               memAddrNext  = bus.if_addr;
               lastIdNext   = ARB_ID_IF;
            end
         end
         ARB_BUSY_IF: begin
            if (bus.mem_ready) begin
               stateNext   = ARB_IDLE;
               memReqNext  = 1'b0;
               memWeNext   = 1'b0;
               ifDoneNext  = 1'b1;
               ifRdataNext = bus.mem_rdata;
            end
         end
         ARB_BUSY_DM: begin
            if (bus.mem_ready) begin
               stateNext  = ARB_IDLE;
               memReqNext = 1'b0;
               memWeNext  = 1'b0;
               dmDoneNext = 1'b1;
               // Stores leave the last load data in place.
               if (!memWe) begin
                  dmRdataNext = bus.mem_rdata;
               end
            end
         end
         default: begin
            stateNext  = ARB_IDLE;
            memReqNext = 1'b0;
            memWeNext  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ARB_IDLE;
         memReq   <= 1'b0;
         memWe    <= 1'b0;
         memAddr  <= '0;
         memWdata <= '0;
         ifDone   <= 1'b0;
         dmDone   <= 1'b0;
         ifRdata  <= '0;
         dmRdata  <= '0;
         lastId   <= ARB_ID_IF;
      end else begin
         state    <= stateNext;
         memReq   <= memReqNext;
         memWe    <= memWeNext;
         memAddr  <= memAddrNext;
         memWdata <= memWdataNext;
         ifDone   <= ifDoneNext;
         dmDone   <= dmDoneNext;
         ifRdata  <= ifRdataNext;
         dmRdata  <= dmRdataNext;
         lastId   <= lastIdNext;
      end
   end

   // Streak only grows while fetch is actually waiting behind a data grant.
   assign streakInc = grantDm && ifElig;
   assign streakClr = (grantDm && !ifElig) || grantIf;

   mem_port_arbiter_dm_streak_counter #(
      .MAX_DM_STREAK (MAX_DM_STREAK)
   ) u_streak (
      .clk      (clk),
      .reset    (reset),
      .inc      (streakInc),
      .clr      (streakClr),
      .count    (dbgStreak),
      .at_limit (streakAtLimit)
   );

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_conflict_cnt <= '0;
         perf_if_stall_cnt <= '0;
      end else begin
         if ((state == ARB_IDLE) && ifElig && dmElig) begin
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
         end
         if (bus.if_req && (state != ARB_BUSY_IF)) begin
            perf_if_stall_cnt <= perf_if_stall_cnt + 32'd1;
         end
      end
   end
`endif

   assign bus.mem_req   = memReq;
   assign bus.mem_we    = memWe;
   assign bus.mem_addr  = memAddr;
   assign bus.mem_wdata = memWdata;
   assign bus.if_done   = ifDone;
   assign bus.dm_done   = dmDone;
   assign bus.if_rdata  = ifRdata;
   assign bus.dm_rdata  = dmRdata;
   assign dbgState      = state;
   assign dbgLastId     = lastId;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, data priority, alternation,
// streak limit, slow memory, reset mid-access and (ARB_PERF_CNT_EN) perf counters.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int ADDR_W        = 32;
   localparam int DATA_W        = 32;
   localparam int MAX_DM_STREAK = 4;
   localparam int STREAK_W      = streakWidth(MAX_DM_STREAK);

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic              autoMem  = 1'b1;
   logic              manReady = 1'b0;
   logic [DATA_W-1:0] manRdata = '0;
   logic [DATA_W-1:0] autoRdata = '0;
   logic [DATA_W-1:0] mem [256];

   arbState_t           dbgState;
   logic [STREAK_W-1:0] dbgStreak;
   logic                dbgLastId;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perfConflict;
   logic [31:0] perfStall;
`endif

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   assign bus.mem_ready = autoMem ? 1'b1 : manReady;
   assign bus.mem_rdata = autoMem ? autoRdata : manRdata;

   mem_port_arbiter #(
      .ADDR_W        (ADDR_W),
      .DATA_W        (DATA_W),
      .MAX_DM_STREAK (MAX_DM_STREAK)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .bus               (bus),
`ifdef ARB_PERF_CNT_EN
      .perf_conflict_cnt (perfConflict),
      .perf_if_stall_cnt (perfStall),
`endif
      .dbgState          (dbgState),
      .dbgStreak         (dbgStreak),
      .dbgLastId         (dbgLastId)
   );

   // clock / reset
   always #5 clk = ~clk;

   // memory model: word i preloaded with 0xA0000000+i, always ready in auto mode
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
      forever begin
         @(negedge clk);
         if (autoMem && bus.mem_req) begin
            autoRdata = mem[bus.mem_addr[9:2]];
            if (bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++; if (dbgState !== ARB_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbgState, ARB_IDLE); end
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
      checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
      checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
      checks++; if ({bus.if_done, bus.dm_done} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b%b expected 00", bus.if_done, bus.dm_done); end
      checks++; if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.if_rdata, bus.dm_rdata); end
      checks++; if (dbgStreak !== 3'd0) begin errors++; $display("FAIL reset_streak: got %0d expected 0", dbgStreak); end
      reset = 1'b0;
   endtask

   task automatic test_fetch();
      bus.if_req = 1'b1; bus.if_addr = 32'h0;
      step();
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL fetch_grant: got req=%b addr=%h we=%b expected 1/0/0", bus.mem_req, bus.mem_addr, bus.mem_we); end
      checks++; if (bus.if_done !== 1'b0) begin errors++; $display("FAIL fetch_early_done: got %b expected 0", bus.if_done); end
      step();
      checks++; if (bus.if_done !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_done: got done=%b req=%b expected 1/0", bus.if_done, bus.mem_req); end
      checks++; if (bus.if_rdata !== 32'hA000_0000) begin errors++; $display("FAIL fetch_rdata: got %h expected a0000000", bus.if_rdata); end
      bus.if_req = 1'b0;
      step();
      checks++; if (bus.if_done !== 1'b0 || bus.if_rdata !== 32'hA000_0000) begin errors++; $display("FAIL fetch_hold: got done=%b rdata=%h expected 0/a0000000", bus.if_done, bus.if_rdata); end
   endtask

   task automatic test_priority_store();
      bus.if_req = 1'b1; bus.if_addr = 32'h8;
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEAD_BEEF;
      step();
      checks++; if (dbgState !== ARB_BUSY_DM || dbgLastId !== ARB_ID_DM) begin errors++; $display("FAIL prio_dm_first: got state=%0d id=%b expected 2/1", dbgState, dbgLastId); end
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL prio_store_bus: got we=%b addr=%h wdata=%h expected 1/100/deadbeef", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      checks++; if (dbgStreak !== 3'd1) begin errors++; $display("FAIL prio_streak_inc: got %0d expected 1", dbgStreak); end
      step();
      checks++; if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 32'h0) begin errors++; $display("FAIL prio_store_done: got done=%b rdata=%h expected 1/0", bus.dm_done, bus.dm_rdata); end
      checks++; if (mem[64] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL prio_mem_written: got %h expected deadbeef", mem[64]); end
      bus.dm_req = 1'b0;
      step();
      checks++; if (dbgState !== ARB_BUSY_IF || bus.mem_addr !== 32'h8 || bus.mem_we !== 1'b0 || dbgLastId !== ARB_ID_IF) begin errors++; $display("FAIL prio_if_next: got state=%0d addr=%h we=%b id=%b expected 1/8/0/0", dbgState, bus.mem_addr, bus.mem_we, dbgLastId); end
      checks++; if (dbgStreak !== 3'd0 || bus.dm_done !== 1'b0) begin errors++; $display("FAIL prio_if_streak: got streak=%0d dm_done=%b expected 0/0", dbgStreak, bus.dm_done); end
      step();
      checks++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'hA000_0002) begin errors++; $display("FAIL prio_if_done: got done=%b rdata=%h expected 1/a0000002", bus.if_done, bus.if_rdata); end
      bus.if_req = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      arbState_t expState [8];
      logic      expDm [8];
      logic      expIf [8];
      arbState_t soloState [6];
      logic      soloDone [6];
      expState  = '{ARB_BUSY_DM, ARB_IDLE, ARB_BUSY_IF, ARB_IDLE, ARB_BUSY_DM, ARB_IDLE, ARB_BUSY_IF, ARB_IDLE};
      expDm     = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      expIf     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      soloState = '{ARB_BUSY_IF, ARB_IDLE, ARB_IDLE, ARB_BUSY_IF, ARB_IDLE, ARB_IDLE};
      soloDone  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      // Both held: done-cycle masking makes the two requesters alternate.
      bus.if_req = 1'b1; bus.if_addr = 32'hC;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h100;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++; if (dbgState !== expState[i] || bus.dm_done !== expDm[i] || bus.if_done !== expIf[i]) begin errors++; $display("FAIL b2b_cycle%0d: got state=%0d dm=%b if=%b expected %0d/%b/%b", i, dbgState, bus.dm_done, bus.if_done, expState[i], expDm[i], expIf[i]); end
         if (i == 1) begin checks++; if (bus.dm_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_load: got %h expected deadbeef", bus.dm_rdata); end end
         if (i == 3) begin checks++; if (bus.if_rdata !== 32'hA000_0003) begin errors++; $display("FAIL b2b_fetch: got %h expected a0000003", bus.if_rdata); end end
         if (i == 4) begin checks++; if (dbgStreak !== 3'd0) begin errors++; $display("FAIL b2b_streak_clr: got %0d expected 0", dbgStreak); end end
      end
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      step();
      bus.if_req = 1'b1; bus.if_addr = 32'h4;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++; if (dbgState !== soloState[i] || bus.if_done !== soloDone[i]) begin errors++; $display("FAIL solo_cycle%0d: got state=%0d done=%b expected %0d/%b", i, dbgState, bus.if_done, soloState[i], soloDone[i]); end
      end
      bus.if_req = 1'b0;
      step();
   endtask

   task automatic test_streak();
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h100; bus.if_addr = 32'h10;
      // Fetch backs off during each data done cycle, so data keeps winning until the limit.
      for (int k = 0; k < 4; k++) begin
         bus.if_req = 1'b1;
         step();
         checks++; if (dbgState !== ARB_BUSY_DM || dbgStreak !== 3'(k + 1)) begin errors++; $display("FAIL streak_dm%0d: got state=%0d streak=%0d expected 2/%0d", k, dbgState, dbgStreak, k + 1); end
         step();
         bus.if_req = 1'b0;
         step();
      end
      bus.if_req = 1'b1;
      step();
      checks++; if (dbgState !== ARB_BUSY_IF || dbgStreak !== 3'd0) begin errors++; $display("FAIL streak_if_wins: got state=%0d streak=%0d expected 1/0", dbgState, dbgStreak); end
      step();
      checks++; if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'hA000_0004) begin errors++; $display("FAIL streak_if_done: got done=%b rdata=%h expected 1/a0000004", bus.if_done, bus.if_rdata); end
      bus.if_req = 1'b0;
      step();
      checks++; if (dbgState !== ARB_BUSY_DM || dbgStreak !== 3'd0) begin errors++; $display("FAIL streak_dm_alone: got state=%0d streak=%0d expected 2/0", dbgState, dbgStreak); end
      step();
      bus.dm_req = 1'b0;
      step();
   endtask

   task automatic test_slow_memory();
      autoMem = 1'b0; manReady = 1'b1;
      step();
      checks++; if (dbgState !== ARB_IDLE || bus.dm_done !== 1'b0 || bus.if_done !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL slow_idle_ready: got state=%0d dm=%b if=%b req=%b expected 0/0/0/0", dbgState, bus.dm_done, bus.if_done, bus.mem_req); end
      manReady = 1'b0;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 || dbgState !== ARB_BUSY_DM || bus.dm_done !== 1'b0) begin errors++; $display("FAIL slow_wait%0d: got req=%b addr=%h state=%0d done=%b expected 1/40/2/0", i, bus.mem_req, bus.mem_addr, dbgState, bus.dm_done); end
         if (i == 1) bus.dm_req = 1'b0;
      end
      manReady = 1'b1; manRdata = 32'h5A5A_1234;
      step();
      checks++; if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 32'h5A5A_1234 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL slow_done: got done=%b rdata=%h req=%b expected 1/5a5a1234/0", bus.dm_done, bus.dm_rdata, bus.mem_req); end
      manReady = 1'b0;
      step();
      checks++; if (bus.dm_done !== 1'b0 || dbgState !== ARB_IDLE) begin errors++; $display("FAIL slow_single_pulse: got done=%b state=%0d expected 0/0", bus.dm_done, dbgState); end
   endtask

   task automatic test_reset_mid_access();
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h80; bus.dm_wdata = 32'h1;
      step();
      checks++; if (dbgState !== ARB_BUSY_DM) begin errors++; $display("FAIL rst_mid_busy: got %0d expected 2", dbgState); end
      reset = 1'b1; bus.dm_req = 1'b0;
      step();
      checks++; if (dbgState !== ARB_IDLE || bus.mem_req !== 1'b0 || bus.dm_done !== 1'b0 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_abandon: got state=%0d req=%b done=%b addr=%h expected 0/0/0/0", dbgState, bus.mem_req, bus.dm_done, bus.mem_addr); end
      reset = 1'b0; manReady = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (bus.dm_done !== 1'b0 || bus.mem_req !== 1'b0 || dbgState !== ARB_IDLE) begin errors++; $display("FAIL rst_mid_late_ready%0d: got done=%b req=%b state=%0d expected 0/0/0", i, bus.dm_done, bus.mem_req, dbgState); end
      end
      manReady = 1'b0; autoMem = 1'b1;
   endtask

`ifdef ARB_PERF_CNT_EN
   task automatic test_perf_counters();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if (perfConflict !== 32'd0 || perfStall !== 32'd0) begin errors++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", perfConflict, perfStall); end
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h100; bus.if_addr = 32'h0;
      for (int k = 0; k < 3; k++) begin
         bus.if_req = 1'b1;
         step();
         step();
         bus.if_req = 1'b0;
         if (k == 2) bus.dm_req = 1'b0;
         step();
         checks++; if (perfConflict !== 32'(k + 1) || perfStall !== 32'(2 * (k + 1))) begin errors++; $display("FAIL perf_iter%0d: got conflict=%0d stall=%0d expected %0d/%0d", k, perfConflict, perfStall, k + 1, 2 * (k + 1)); end
      end
   endtask
`endif

   initial begin
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      test_reset();
      test_fetch();
      test_priority_store();
      test_back_to_back();
      test_streak();
      test_slow_memory();
      test_reset_mid_access();
`ifdef ARB_PERF_CNT_EN
      test_perf_counters();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
